ahb_slave_port: RTL and testbench

- Downstream adapter on each slave-side port of the AHB interconnect. Converts the interconnect's split handshake (s_addr_req/s_addr_ack/s_data_ack) into a standard AHB-Lite slave interface (HSEL, HREADY, HREADYOUT, HRESP).
- Tracks the outstanding data phase itself and completes null transfers locally.
- Includes an optional watchdog. It terminates a hung data phase with an error so the granted master is never blocked forever.

---
 rtl/ahb_slave_port_pkg.sv | 23 ++
 rtl/ahb_slave_port.sv | 114 +++++++++++
 tb/tb_ahb_slave_port.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_port_pkg.sv
// Shared encodings for the AHB slave-port adapter: bus transfer/response codes,
// adapter state encoding and the default data returned on a watchdog timeout.
package ahb_slave_port_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DATA  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam logic [31:0] DEAD_DATA_DEF = 32'hdeaddead;

endpackage

// File: rtl/ahb_slave_port.sv
// Converts the interconnect's split address/data handshake into an AHB-Lite slave
// port, completes null transfers locally and optionally times out hung data phases.
module ahb_slave_port
  import ahb_slave_port_pkg::*;
#(
  parameter int          TIMEOUT   = 0,
  parameter int          TOCNT_BIT = $clog2(TIMEOUT + 2),
  parameter logic [31:0] DEAD_DATA = DEAD_DATA_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        s_addr_req,
  output logic        s_addr_ack,
  output logic        s_data_ack,
  input  logic        s_hsel,
  input  logic [1:0]  s_htrans,
  input  logic        s_hwrite,
  input  logic        s_hmastlock,
  input  logic [2:0]  s_hsize,
  input  logic [2:0]  s_hburst,
  input  logic [3:0]  s_hprot,
  input  logic [31:0] s_haddr,
  input  logic [31:0] s_hwdata,
  output logic [31:0] s_hrdata,
  output logic        s_hresp,
  output logic        HSEL,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic        HMASTLOCK,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  input  logic        HREADYOUT,
  input  logic [31:0] HRDATA,
  input  logic        HRESP,
  output logic        timeout_evt
);

  localparam bit                   WDOG_EN = (TIMEOUT > 0);
  localparam logic [TOCNT_BIT-1:0] TO_MAX  = TOCNT_BIT'(TIMEOUT);
  localparam logic [TOCNT_BIT-1:0] TO_LAST = TOCNT_BIT'(WDOG_EN ? TIMEOUT - 1 : 0);

  state_e               state, state_nxt;
  logic                 dnull, dnull_nxt;
  logic [TOCNT_BIT-1:0] tocnt, tocnt_nxt;
  logic                 av, hrdy, real_dp, stall, wdog_fire;

  assign av        = s_addr_req & (state != ST_DRAIN);
  assign real_dp   = (state == ST_DATA) & ~dnull;
  assign stall     = real_dp & ~HREADYOUT;
  // A slave that goes ready on the firing cycle wins: stall already excludes it.
  assign wdog_fire = WDOG_EN & stall & (tocnt == TO_LAST);

  always_comb begin
    hrdy = 1'b1;
    case (state)
      ST_DATA:  hrdy = dnull | HREADYOUT;
      ST_DRAIN: hrdy = HREADYOUT;
      default:  hrdy = 1'b1;
    endcase
  end

  assign HSEL       = av & s_hsel;
  assign HTRANS     = av ? s_htrans : HTRANS_IDLE;
  assign HWRITE     = s_hwrite;
  assign HMASTLOCK  = s_hmastlock;
  assign HSIZE      = s_hsize;
  assign HBURST     = s_hburst;
  assign HPROT      = s_hprot;
  assign HADDR      = s_haddr;
  assign HWDATA     = s_hwdata;
  assign HREADY     = hrdy;

  assign s_addr_ack = av & hrdy;
  assign s_data_ack = (state == ST_DATA) & (dnull | HREADYOUT | wdog_fire);
  assign s_hresp    = wdog_fire | (real_dp & HRESP);
  assign s_hrdata   = wdog_fire ? DEAD_DATA : (real_dp ? HRDATA : 32'h0);

  always_comb begin
    state_nxt = state;
    dnull_nxt = dnull;
    tocnt_nxt = tocnt;
    if (s_addr_ack) begin
      state_nxt = ST_DATA;
      dnull_nxt = ~(s_hsel & s_htrans[1]);
      tocnt_nxt = '0;
    end else if (s_data_ack) begin
      state_nxt = wdog_fire ? ST_DRAIN : ST_IDLE;
    end else if ((state == ST_DRAIN) && HREADYOUT) begin
      // The late slave completion was already reported as a timeout; drop it.
      state_nxt = ST_IDLE;
    end else if (WDOG_EN && stall && (tocnt != TO_MAX)) begin
      tocnt_nxt = tocnt + TOCNT_BIT'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      dnull       <= 1'b0;
      tocnt       <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      dnull       <= dnull_nxt;
      tocnt       <= tocnt_nxt;
      timeout_evt <= wdog_fire;
    end
  end

endmodule

// File: tb/tb_ahb_slave_port.sv
// Directed bench for ahb_slave_port with a 4-cycle watchdog.
module tb_ahb_slave_port;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        s_addr_req, s_addr_ack, s_data_ack, s_hsel;
  logic [1:0]  s_htrans;
  logic        s_hwrite, s_hmastlock;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hresp;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HADDR, HWDATA;
  logic        HREADY, HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP, timeout_evt;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_port #(.TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .s_addr_req(s_addr_req), .s_addr_ack(s_addr_ack), .s_data_ack(s_data_ack),
    .s_hsel(s_hsel), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hmastlock(s_hmastlock), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hprot(s_hprot), .s_haddr(s_haddr), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hresp(s_hresp),
    .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .timeout_evt(timeout_evt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a);
    s_addr_req = 1'b1; s_hsel = sel; s_htrans = tr; s_hwrite = wr; s_haddr = a;
  endtask

  initial begin
    HRESETn = 1'b0; s_addr_req = 1'b0; s_hsel = 1'b0; s_htrans = 2'b00;
    s_hwrite = 1'b0; s_hmastlock = 1'b0; s_hsize = 3'd2; s_hburst = 3'd0;
    s_hprot = 4'h3; s_haddr = '0; s_hwdata = '0;
    HREADYOUT = 1'b1; HRDATA = 32'hAAAA5555; HRESP = 1'b0;

    // Reset state
    #12;
    check("rst_hready", HREADY, 1);
    check("rst_hsel", HSEL, 0);
    check("rst_htrans", HTRANS, 0);
    check("rst_data_ack", s_data_ack, 0);
    check("rst_hresp", s_hresp, 0);
    check("rst_hrdata", s_hrdata, 0);
    check("rst_tevt", timeout_evt, 0);
    HRESETn = 1'b1;
    step();

    // Zero-wait read
    req(1, 2'b10, 0, 32'h100); #1;
    check("rd_addr_ack", s_addr_ack, 1);
    check("rd_hsel", HSEL, 1);
    check("rd_htrans", HTRANS, 2'b10);
    check("rd_haddr", HADDR, 32'h100);
    step();
    s_addr_req = 0; HRDATA = 32'h12345678; #1;
    check("rd_data_ack", s_data_ack, 1);
    check("rd_hrdata", s_hrdata, 32'h12345678);
    check("rd_hresp", s_hresp, 0);
    check("rd_no_addr_ack", s_addr_ack, 0);
    step();

    // Write with two wait states, pipelined read behind it
    req(1, 2'b10, 1, 32'h200); #1;
    check("wr_addr_ack", s_addr_ack, 1);
    check("wr_hwrite", HWRITE, 1);
    step();
    req(1, 2'b10, 0, 32'h204); s_hwdata = 32'hCAFEF00D; HREADYOUT = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wr_wait_data_ack", s_data_ack, 0);
      check("wr_wait_addr_ack", s_addr_ack, 0);
      check("wr_wait_hready", HREADY, 0);
      check("wr_wait_hwdata", HWDATA, 32'hCAFEF00D);
      step();
    end
    HREADYOUT = 1; #1;
    check("wr_data_ack", s_data_ack, 1);
    check("wr_pipe_addr_ack", s_addr_ack, 1);
    check("wr_hwdata", HWDATA, 32'hCAFEF00D);
    step();
    s_addr_req = 0; HRDATA = 32'h55AA00FF; #1;
    check("pipe_rd_data_ack", s_data_ack, 1);
    check("pipe_rd_hrdata", s_hrdata, 32'h55AA00FF);
    step();

    // Accepted IDLE transfer, deselected: completes locally
    req(0, 2'b00, 0, 32'h300); #1;
    check("idle_addr_ack", s_addr_ack, 1);
    check("idle_hsel", HSEL, 0);
    check("idle_htrans", HTRANS, 0);
    step();
    s_addr_req = 0; HREADYOUT = 0; HRESP = 1; HRDATA = 32'hFFFFFFFF; #1;
    check("idle_data_ack", s_data_ack, 1);
    check("idle_hresp", s_hresp, 0);
    check("idle_hrdata", s_hrdata, 0);
    check("idle_hready", HREADY, 1);
    step();
    HREADYOUT = 1; HRESP = 0;

    // Two-cycle slave ERROR
    req(1, 2'b10, 0, 32'h310); #1;
    check("err_addr_ack", s_addr_ack, 1);
    step();
    req(1, 2'b10, 0, 32'h314); HREADYOUT = 0; HRESP = 1; #1;
    check("err1_data_ack", s_data_ack, 0);
    check("err1_addr_ack", s_addr_ack, 0);
    step();
    s_addr_req = 0; HREADYOUT = 1; #1;
    check("err2_data_ack", s_data_ack, 1);
    check("err2_hresp", s_hresp, 1);
    step();
    HRESP = 0;

    // Watchdog fires on 4th stall cycle
    req(1, 2'b10, 0, 32'h400); #1;
    check("to_addr_ack", s_addr_ack, 1);
    step();
    s_addr_req = 0; HREADYOUT = 0; HRDATA = 32'h01020304;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("to_stall_data_ack", s_data_ack, 0);
      check("to_stall_hresp", s_hresp, 0);
      step();
    end
    #1;
    check("to_fire_data_ack", s_data_ack, 1);
    check("to_fire_hresp", s_hresp, 1);
    check("to_fire_hrdata", s_hrdata, 32'hdeaddead);
    check("to_fire_tevt", timeout_evt, 0);
    step();
    req(1, 2'b10, 0, 32'h500); #1;
    check("drain_tevt", timeout_evt, 1);
    check("drain_addr_ack", s_addr_ack, 0);
    check("drain_hsel", HSEL, 0);
    check("drain_htrans", HTRANS, 0);
    check("drain_data_ack", s_data_ack, 0);
    step(); #1;
    check("drain2_tevt", timeout_evt, 0);
    check("drain2_addr_ack", s_addr_ack, 0);
    step();
    HREADYOUT = 1; #1;
    check("drain_end_addr_ack", s_addr_ack, 0);
    check("drain_end_data_ack", s_data_ack, 0);
    step(); #1;
    check("post_drain_addr_ack", s_addr_ack, 1);
    step();
    s_addr_req = 0; HRDATA = 32'h0BADF00D; #1;
    check("post_drain_data_ack", s_data_ack, 1);
    check("post_drain_hrdata", s_hrdata, 32'h0BADF00D);
    step();

    // Slave ready on the would-be firing cycle wins over the watchdog
    req(1, 2'b10, 0, 32'h600); step();
    s_addr_req = 0; HREADYOUT = 0;
    step(); step(); step();
    HREADYOUT = 1; HRDATA = 32'h600D600D; #1;
    check("race_data_ack", s_data_ack, 1);
    check("race_hresp", s_hresp, 0);
    check("race_hrdata", s_hrdata, 32'h600D600D);
    step(); #1;
    check("race_tevt", timeout_evt, 0);
    check("race_idle_hready", HREADY, 1);

    // Asynchronous reset in a stalled data phase
    req(1, 2'b10, 0, 32'h700); step();
    s_addr_req = 0; HREADYOUT = 0; #1;
    check("pre_rst_hready", HREADY, 0);
    #2 HRESETn = 0; #1;
    check("arst_hsel", HSEL, 0);
    check("arst_hready", HREADY, 1);
    check("arst_data_ack", s_data_ack, 0);
    @(negedge HCLK); HRESETn = 1;
    step();
    req(1, 2'b10, 0, 32'h800); HREADYOUT = 1; #1;
    check("after_rst_addr_ack", s_addr_ack, 1);
    step();
    s_addr_req = 0; HRDATA = 32'h80808080; #1;
    check("after_rst_data_ack", s_data_ack, 1);
    check("after_rst_hrdata", s_hrdata, 32'h80808080);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
